// File: rtl/clock_alarm_pkg.sv
// Shared definitions for the clock/alarm time-setting logic.
// Holds the time-field widths, calendar constants and the state encoding
// of the time_set_sequencer FSM.
package clock_alarm_pkg;

  localparam int unsigned MINS_PER_HOUR = 60;
  localparam int unsigned HOURS_PER_DAY = 24;
  localparam int unsigned HALF_DAY      = 12;

  localparam int unsigned HOUR_W = 4;
  localparam int unsigned MIN_W  = 6;
  // Width of a 0..23 hour-of-day value.
  localparam int unsigned H24_W  = $clog2(HOURS_PER_DAY);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MIN_CHK   = 3'd1,
    S_MIN_PULSE = 3'd2,
    S_MIN_WAIT  = 3'd3,
    S_HR_CHK    = 3'd4,
    S_HR_PULSE  = 3'd5,
    S_HR_WAIT   = 3'd6,
    S_FINAL_CHK = 3'd7
  } set_state_e;

endpackage

// File: rtl/time_set_sequencer.sv
// Closed-loop time setter for the clock/alarm counter.
// On a load request it steps the counter forward with single-cycle MINS
// then HOURS pulses, re-reading the counter after each pulse, until the
// counter shows the requested 12-hour time; then it pulses done.
// While idle the 1 Hz tick is passed through to the counter on SECS.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   load_req                   start request (sampled in IDLE only)
//   tgt_hours/mins/am_pm       requested time (hours 0..11, mins 0..59)
//   abort                      cancel an operation in progress
//   sec_tick                   1 Hz tick from the prescaler
//   HOURS_IN/MINUTES_IN/AM_PM_IN  counter read-back
//   HOURS/MINS                 increment pulses to the counter
//   SECS                       gated seconds tick (combinational)
//   busy/done/err              status: in progress, success, failure
module time_set_sequencer
  import clock_alarm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 511,
  parameter int unsigned PULSE_GAP   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic [HOUR_W-1:0] tgt_hours,
  input  logic [MIN_W-1:0]  tgt_mins,
  input  logic              tgt_am_pm,
  input  logic              abort,
  input  logic              sec_tick,
  input  logic [HOUR_W-1:0] HOURS_IN,
  input  logic [MIN_W-1:0]  MINUTES_IN,
  input  logic              AM_PM_IN,
  output logic              HOURS,
  output logic              MINS,
  output logic              SECS,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned GAP_W = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(PULSE_GAP - 1);

  set_state_e        r_state;
  logic [HOUR_W-1:0] r_tgt_hours;
  logic [MIN_W-1:0]  r_tgt_mins;
  logic              r_tgt_am_pm;
  logic [TO_W-1:0]   r_to_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              r_hours;
  logic              r_mins;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  set_state_e        w_state_nxt;
  logic              w_done_nxt;
  logic              w_err_nxt;
  logic              w_latch;
  logic              w_tgt_bad;
  logic              w_min_match;
  logic              w_hr_match;
  logic              w_gap_last;
  logic              w_timeout;
  logic [H24_W-1:0]  w_cur24;
  logic [H24_W-1:0]  w_tgt24;

  // Hours are compared on a 0..23 scale so AM/PM is stepped like any hour.
  assign w_cur24 = (AM_PM_IN ? H24_W'(HALF_DAY) : H24_W'(0)) + H24_W'(HOURS_IN);
  assign w_tgt24 = (r_tgt_am_pm ? H24_W'(HALF_DAY) : H24_W'(0)) + H24_W'(r_tgt_hours);

  assign w_tgt_bad   = (tgt_hours > HOUR_W'(HALF_DAY - 1)) ||
                       (tgt_mins > MIN_W'(MINS_PER_HOUR - 1));
  assign w_min_match = (MINUTES_IN == r_tgt_mins);
  assign w_hr_match  = (w_cur24 == w_tgt24);
  assign w_gap_last  = (r_gap_cnt == GAP_LAST);
  assign w_timeout   = (r_to_cnt == TO_LAST);

  // The counter must not see seconds while it is being stepped.
  assign SECS  = sec_tick & ~r_busy & ~reset;
  assign HOURS = r_hours;
  assign MINS  = r_mins;
  assign busy  = r_busy;
  assign done  = r_done;
  assign err   = r_err;

  // State, target, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tgt_hours <= '0;
      r_tgt_mins  <= '0;
      r_tgt_am_pm <= 1'b0;
      r_to_cnt    <= '0;
      r_gap_cnt   <= '0;
      r_hours     <= 1'b0;
      r_mins      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_tgt_hours <= tgt_hours;
        r_tgt_mins  <= tgt_mins;
        r_tgt_am_pm <= tgt_am_pm;
      end
      r_to_cnt  <= (r_state == S_IDLE) ? '0 : r_to_cnt + TO_W'(1);
      r_gap_cnt <= (r_state == S_MIN_WAIT || r_state == S_HR_WAIT) ?
                   r_gap_cnt + GAP_W'(1) : '0;
      r_mins  <= (w_state_nxt == S_MIN_PULSE);
      r_hours <= (w_state_nxt == S_HR_PULSE);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state and status decode.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_latch     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (load_req) begin
          if (w_tgt_bad) begin
            w_err_nxt = 1'b1;
          end else begin
            w_latch     = 1'b1;
            w_state_nxt = S_MIN_CHK;
          end
        end
      end
      S_MIN_CHK:   w_state_nxt = w_min_match ? S_HR_CHK : S_MIN_PULSE;
      S_MIN_PULSE: w_state_nxt = S_MIN_WAIT;
      S_MIN_WAIT:  if (w_gap_last) w_state_nxt = S_MIN_CHK;
      S_HR_CHK:    w_state_nxt = w_hr_match ? S_FINAL_CHK : S_HR_PULSE;
      S_HR_PULSE:  w_state_nxt = S_HR_WAIT;
      S_HR_WAIT:   if (w_gap_last) w_state_nxt = S_HR_CHK;
      S_FINAL_CHK: begin
        // A minute wrap during the hour phase is impossible, but re-run
        // both phases rather than trust that.
        if (w_min_match && w_hr_match) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_MIN_CHK;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort silences everything; a success in the last cycle beats timeout.
    if (r_state != S_IDLE) begin
      if (abort) begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b0;
      end else if (w_timeout && !w_done_nxt) begin
        w_state_nxt = S_IDLE;
        w_err_nxt   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_time_set_sequencer.sv
// Self-checking bench for time_set_sequencer: a behavioural 12-hour
// counter closes the loop; a vector table of loads is checked through a
// scoreboard, followed by abort, reset and timeout sequences.
module tb_time_set_sequencer;

  localparam int GAP = 2;
  localparam int TO2 = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, load_req, load_req2, abort, sec_tick, tick_force;
  logic [3:0] tgt_hours;
  logic [5:0] tgt_mins;
  logic       tgt_am_pm;
  logic       HOURS, MINS, SECS, busy, done, err;
  logic       HOURS2, MINS2, SECS2, busy2, done2, err2;

  // Behavioural time counter fed by the main DUT.
  logic [3:0] c_h = 4'd0;
  logic [5:0] c_m = 6'd0;
  logic       c_ap = 1'b0;
  int         c_mins_n = 0;
  int         c_hrs_n = 0;
  logic       c_ld = 1'b0;
  logic [3:0] c_ld_h = 4'd0;
  logic [5:0] c_ld_m = 6'd0;
  logic       c_ld_ap = 1'b0;

  int unsigned cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] sh; logic [5:0] sm; logic sap;
    logic [3:0] th; logic [5:0] tm; logic tap;
    logic ab; logic noisy; logic xerr;
    int mp; int hp;
    logic [3:0] eh; logic [5:0] em; logic eap;
  } vec_t;

  typedef struct {
    logic xerr; int mp; int hp;
    logic [3:0] eh; logic [5:0] em; logic eap;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];

  time_set_sequencer dut (
    .clk(clk), .reset(reset), .load_req(load_req),
    .tgt_hours(tgt_hours), .tgt_mins(tgt_mins), .tgt_am_pm(tgt_am_pm),
    .abort(abort), .sec_tick(sec_tick),
    .HOURS_IN(c_h), .MINUTES_IN(c_m), .AM_PM_IN(c_ap),
    .HOURS(HOURS), .MINS(MINS), .SECS(SECS),
    .busy(busy), .done(done), .err(err)
  );

  // Second instance with a frozen counter and a short timeout.
  time_set_sequencer #(.TIMEOUT_CYC(TO2)) dut_to (
    .clk(clk), .reset(reset), .load_req(load_req2),
    .tgt_hours(tgt_hours), .tgt_mins(tgt_mins), .tgt_am_pm(tgt_am_pm),
    .abort(abort), .sec_tick(sec_tick),
    .HOURS_IN(4'd0), .MINUTES_IN(6'd0), .AM_PM_IN(1'b0),
    .HOURS(HOURS2), .MINS(MINS2), .SECS(SECS2),
    .busy(busy2), .done(done2), .err(err2)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (c_ld) begin
      c_h <= c_ld_h; c_m <= c_ld_m; c_ap <= c_ld_ap;
      c_mins_n <= 0; c_hrs_n <= 0;
    end else begin
      if (MINS) begin
        c_mins_n <= c_mins_n + 1;
        if (c_m == 6'd59) begin
          c_m <= 6'd0;
          if (c_h == 4'd11) begin c_h <= 4'd0; c_ap <= ~c_ap; end
          else c_h <= c_h + 4'd1;
        end else begin
          c_m <= c_m + 6'd1;
        end
      end
      if (HOURS) begin
        c_hrs_n <= c_hrs_n + 1;
        if (c_h == 4'd11) begin c_h <= 4'd0; c_ap <= ~c_ap; end
        else c_h <= c_h + 4'd1;
      end
    end
  end

  // Seconds tick every 4 cycles, or held high on request.
  initial begin
    sec_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sec_tick = tick_force | ((cyc % 4) == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Preset the counter, issue one load; returns at the first negedge after it.
  task automatic start_load(input vec_t v);
    @(negedge clk);
    c_ld = 1'b1; c_ld_h = v.sh; c_ld_m = v.sm; c_ld_ap = v.sap;
    @(negedge clk);
    c_ld = 1'b0;
    tgt_hours = v.th; tgt_mins = v.tm; tgt_am_pm = v.tap;
    load_req = 1'b1; abort = v.ab;
    @(negedge clk);
    load_req = 1'b0; abort = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e, g;
    int busy_bad, secs_bad, space_bad, idle_bad, last_m, last_h, now_c;
    logic seen;
    e = '{v.xerr, v.mp, v.hp, v.eh, v.em, v.eap};
    sb.push_back(e);
    start_load(v);
    busy_bad = 0; secs_bad = 0; space_bad = 0; idle_bad = 0;
    last_m = -1; last_h = -1; seen = 1'b0;
    for (int k = 0; k < 800; k++) begin
      if (done || err) begin seen = 1'b1; break; end
      now_c = int'(cyc);
      if (busy !== !v.xerr) busy_bad++;
      if (SECS !== (sec_tick & v.xerr)) secs_bad++;
      if (MINS && HOURS) space_bad++;
      if (MINS) begin
        if (last_m >= 0 && now_c - last_m != GAP + 2) space_bad++;
        last_m = now_c;
      end
      if (HOURS) begin
        if (last_h >= 0 && now_c - last_h != GAP + 2) space_bad++;
        last_h = now_c;
      end
      if (v.noisy) begin
        load_req = 1'b1; tgt_hours = 4'd15; tgt_mins = 6'd63; tgt_am_pm = !v.tap;
      end
      @(negedge clk);
    end
    load_req = 1'b0;
    check($sformatf("v%0d_finished", idx), 32'(seen), 1);
    g = sb.pop_front();
    check($sformatf("v%0d_done", idx), 32'(done), 32'(!g.xerr));
    check($sformatf("v%0d_err", idx), 32'(err), 32'(g.xerr));
    check($sformatf("v%0d_busy_end", idx), 32'(busy), 0);
    check($sformatf("v%0d_min_pulses", idx), c_mins_n, g.mp);
    check($sformatf("v%0d_hr_pulses", idx), c_hrs_n, g.hp);
    check($sformatf("v%0d_cnt_hours", idx), 32'(c_h), 32'(g.eh));
    check($sformatf("v%0d_cnt_mins", idx), 32'(c_m), 32'(g.em));
    check($sformatf("v%0d_cnt_ampm", idx), 32'(c_ap), 32'(g.eap));
    check($sformatf("v%0d_busy_during", idx), busy_bad, 0);
    check($sformatf("v%0d_secs_gated", idx), secs_bad, 0);
    check($sformatf("v%0d_pulse_spacing", idx), space_bad, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (SECS !== sec_tick || done || err || busy || MINS || HOURS) idle_bad++;
    end
    check($sformatf("v%0d_idle_after", idx), idle_bad, 0);
  endtask

  initial begin
    vec_t va;
    int bad, snap_m, snap_h, n, p2_m, p2_h, secs2_bad;
    logic seen2, done2_seen;

    //        sh    sm    sap   th    tm    tap   ab    noisy xerr  mp  hp  eh    em    eap
    vecs[0] = '{4'd0, 6'd0, 1'b0, 4'd3, 6'd15,1'b1, 1'b0, 1'b0, 1'b0, 15, 15, 4'd3, 6'd15,1'b1};
    vecs[1] = '{4'd10,6'd50,1'b0, 4'd10,6'd5, 1'b0, 1'b0, 1'b1, 1'b0, 15, 23, 4'd10,6'd5, 1'b0};
    vecs[2] = '{4'd0, 6'd0, 1'b0, 4'd12,6'd30,1'b0, 1'b0, 1'b0, 1'b1, 0,  0,  4'd0, 6'd0, 1'b0};
    vecs[3] = '{4'd4, 6'd20,1'b1, 4'd5, 6'd60,1'b0, 1'b0, 1'b0, 1'b1, 0,  0,  4'd4, 6'd20,1'b1};
    vecs[4] = '{4'd7, 6'd20,1'b1, 4'd7, 6'd20,1'b1, 1'b0, 1'b0, 1'b0, 0,  0,  4'd7, 6'd20,1'b1};
    vecs[5] = '{4'd11,6'd59,1'b1, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1,  0,  4'd0, 6'd0, 1'b0};
    vecs[6] = '{4'd0, 6'd0, 1'b0, 4'd11,6'd59,1'b1, 1'b0, 1'b0, 1'b0, 59, 23, 4'd11,6'd59,1'b1};
    vecs[7] = '{4'd5, 6'd10,1'b0, 4'd5, 6'd9, 1'b0, 1'b0, 1'b1, 1'b0, 59, 23, 4'd5, 6'd9, 1'b0};
    vecs[8] = '{4'd2, 6'd0, 1'b0, 4'd15,6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 0,  0,  4'd2, 6'd0, 1'b0};
    vecs[9] = '{4'd0, 6'd3, 1'b0, 4'd0, 6'd5, 1'b0, 1'b1, 1'b0, 1'b0, 2,  0,  4'd0, 6'd5, 1'b0};

    reset = 1'b1; tick_force = 1'b1;
    load_req = 1'b0; load_req2 = 1'b0; abort = 1'b0;
    tgt_hours = 4'd0; tgt_mins = 6'd0; tgt_am_pm = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sec_tick_high", 32'(sec_tick), 1);
    check("rst_secs", 32'(SECS), 0);
    check("rst_outputs", {26'd0, HOURS, MINS, busy, done, err, busy2}, 0);
    reset = 1'b0; tick_force = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Abort ten cycles into a load: three MINS pulses issued, then silence.
    va = vecs[0];
    start_load(va);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_done_err", {30'd0, done, err}, 0);
    snap_m = c_mins_n; snap_h = c_hrs_n;
    check("abort_pulses_before", snap_m, 3);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy || done || err || MINS || HOURS) bad++;
    end
    check("abort_quiet", bad, 0);
    check("abort_no_more_pulses", c_mins_n + c_hrs_n, snap_m + snap_h);

    // Reset in the middle of a load.
    start_load(va);
    repeat (12) @(negedge clk);
    reset = 1'b1; tick_force = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_outputs", {27'd0, HOURS, MINS, busy, done, err}, 0);
    check("midrst_secs", {30'd0, sec_tick, SECS}, 2);
    reset = 1'b0; tick_force = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy || done || err || MINS || HOURS) bad++;
    end
    check("midrst_stays_idle", bad, 0);

    // Frozen counter: the short-timeout instance must give up after TO2 busy cycles.
    @(negedge clk);
    tgt_hours = 4'd3; tgt_mins = 6'd15; tgt_am_pm = 1'b1; load_req2 = 1'b1;
    @(negedge clk);
    load_req2 = 1'b0;
    check("to_busy_rise", 32'(busy2), 1);
    n = 0; seen2 = 1'b0; done2_seen = 1'b0; secs2_bad = 0;
    p2_m = MINS2 ? 1 : 0; p2_h = HOURS2 ? 1 : 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      n++;
      if (done2) done2_seen = 1'b1;
      if (err2) begin seen2 = 1'b1; break; end
      if (MINS2) p2_m++;
      if (HOURS2) p2_h++;
      if (SECS2 || !busy2) secs2_bad++;
    end
    check("to_err_seen", 32'(seen2), 1);
    check("to_latency", n, TO2);
    check("to_no_done", 32'(done2_seen), 0);
    check("to_busy_at_err", 32'(busy2), 0);
    check("to_min_pulses", p2_m, 16);
    check("to_hr_pulses", p2_h, 0);
    check("to_busy_secs", secs2_bad, 0);
    @(negedge clk);
    check("to_err_width", {30'd0, err2, busy2}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
